// File: rtl/x_sram_sched.sv
// Request scheduler between one host port and p_banks SPI SRAM data engines:
// one outstanding access per bank, read responses returned in request order.
// Optional feature macro: X_SRAM_SCHED_WR_ACK_EN (writes also produce a response).
module x_sram_sched #(
  parameter  int p_banks = 16,
  localparam int BW      = $clog2(p_banks)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_rd_n_wr,
  input  logic [15+BW:0]         i_req_addr,
  input  logic [7:0]             i_req_wdata,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [BW-1:0]          o_rsp_bank,
  output logic [7:0]             o_rsp_data,
  output logic [p_banks-1:0]     o_valid,
  input  logic [p_banks-1:0]     i_accept,
  output logic                   o_rd_n_wr,
  output logic [15:0]            o_addr,
  output logic [7:0]             o_wdata,
  input  logic [p_banks-1:0]     i_ready,
  input  logic [8*p_banks-1:0]   i_rdata,
  output logic                   o_fsm_state
);

  // Handshakes: a transfer happens on a rising clock edge where valid & ready
  // (host request / host response) or o_valid[b] & i_accept[b] (engine) are high.

  typedef enum logic {S_IDLE = 1'b0, S_DISPATCH = 1'b1} state_t;

  state_t             state;
  logic [p_banks-1:0] busy;
  logic [p_banks-1:0] done;
  logic [p_banks-1:0] trk;
  logic [p_banks-1:0] rd;
  logic [7:0]         rdat [p_banks];
  logic [BW-1:0]      fifo [p_banks];
  logic [BW-1:0]      wr_ptr;
  logic [BW-1:0]      rd_ptr;
  logic [BW:0]        count;
  logic [BW-1:0]      cur_bank;
  logic               cur_trk;
  logic [BW-1:0]      req_bank;
  logic [BW-1:0]      head;
  logic               req_tracked;
  logic               req_fire;
  logic               acc_fire;
  logic               push;
  logic               pop;
  logic               fifo_empty;

  assign req_bank = i_req_addr[15+BW:16];

`ifdef X_SRAM_SCHED_WR_ACK_EN
  assign req_tracked = 1'b1;
`else
  assign req_tracked = i_req_rd_n_wr;
`endif

  assign o_req_ready = (state == S_IDLE) & ~busy[req_bank] & ~done[req_bank] & ~(|o_valid);
  assign req_fire    = i_req_valid & o_req_ready;
  assign acc_fire    = (state == S_DISPATCH) & i_accept[cur_bank];
  assign push        = acc_fire & cur_trk;

  assign fifo_empty  = (count == '0);
  assign head        = fifo[rd_ptr];
  assign o_rsp_valid = ~fifo_empty & done[head];
  assign o_rsp_bank  = o_rsp_valid ? head : '0;
  assign o_rsp_data  = o_rsp_valid ? rdat[head] : 8'h00;
  assign pop         = o_rsp_valid & i_rsp_ready;
  assign o_fsm_state = (state == S_DISPATCH);

  // Dispatch FSM: shared bus is latched on host handshake and held until accept.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= S_IDLE;
      o_valid   <= '0;
      o_rd_n_wr <= 1'b0;
      o_addr    <= '0;
      o_wdata   <= '0;
      cur_bank  <= '0;
      cur_trk   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            o_rd_n_wr <= i_req_rd_n_wr;
            o_addr    <= i_req_addr[15:0];
            o_wdata   <= i_req_wdata;
            o_valid   <= {{(p_banks-1){1'b0}}, 1'b1} << req_bank;
            cur_bank  <= req_bank;
            cur_trk   <= req_tracked;
            state     <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (acc_fire) begin
            o_valid <= '0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-bank bookkeeping; stray ready pulses on idle banks fall through.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      busy <= '0;
      done <= '0;
      trk  <= '0;
      rd   <= '0;
      for (int b = 0; b < p_banks; b++) rdat[b] <= 8'h00;
    end else begin
      for (int b = 0; b < p_banks; b++) begin
        if (req_fire && req_bank == BW'(b)) begin
          trk[b] <= req_tracked;
          rd[b]  <= i_req_rd_n_wr;
        end
        if (acc_fire && cur_bank == BW'(b)) begin
          busy[b] <= 1'b1;
        end else if (i_ready[b] && busy[b]) begin
          busy[b] <= 1'b0;
          rdat[b] <= rd[b] ? i_rdata[8*b +: 8] : 8'h00;
          done[b] <= trk[b];
        end
        if (pop && head == BW'(b)) done[b] <= 1'b0;
      end
    end
  end

  // Order FIFO: at most one entry per bank, so it can never overflow.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < p_banks; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= cur_bank;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_x_sram_sched.sv
// Self-checking bench for x_sram_sched (16 banks); adapts to X_SRAM_SCHED_WR_ACK_EN.
module tb_x_sram_sched;

  localparam int NB = 16;
  localparam int BW = 4;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_req_valid = 1'b0;
  logic              o_req_ready;
  logic              i_req_rd_n_wr = 1'b0;
  logic [15+BW:0]    i_req_addr = '0;
  logic [7:0]        i_req_wdata = '0;
  logic              o_rsp_valid;
  logic              i_rsp_ready = 1'b0;
  logic [BW-1:0]     o_rsp_bank;
  logic [7:0]        o_rsp_data;
  logic [NB-1:0]     o_valid;
  logic [NB-1:0]     i_accept = '0;
  logic              o_rd_n_wr;
  logic [15:0]       o_addr;
  logic [7:0]        o_wdata;
  logic [NB-1:0]     i_ready = '0;
  logic [8*NB-1:0]   i_rdata = '0;
  logic              o_fsm_state;

  logic [11:0] exp_q[$];
  logic [7:0]  eng_data [NB];
  int          n_checks = 0;
  int          n_errors = 0;
  int          acc_dly = 0;
  int          acc_wait = 0;
  int          vcnt3 = 0;
  int          perm [NB];

  x_sram_sched #(.p_banks(NB)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_rd_n_wr(i_req_rd_n_wr), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_bank(o_rsp_bank), .o_rsp_data(o_rsp_data),
    .o_valid(o_valid), .i_accept(i_accept),
    .o_rd_n_wr(o_rd_n_wr), .o_addr(o_addr), .o_wdata(o_wdata),
    .i_ready(i_ready), .i_rdata(i_rdata), .o_fsm_state(o_fsm_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Engine accept model: accepts the dispatching bank acc_dly cycles after o_valid rises.
  initial forever begin
    @(posedge i_clk); #1;
    i_accept = '0;
    if ((|o_valid) && i_rst) begin
      if (acc_wait >= acc_dly) begin
        i_accept = o_valid;
        acc_wait = 0;
      end else begin
        acc_wait++;
      end
    end else begin
      acc_wait = 0;
    end
  end

  // Response scoreboard: compare each popped response with the head of exp_q.
  initial forever begin
    logic [11:0] e;
    @(negedge i_clk);
    if (i_rst) begin
      if (o_valid[3]) vcnt3++;
      if (o_rsp_valid && i_rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(o_rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_bank", 32'(o_rsp_bank), 32'(e[11:8]));
          check("rsp_data", 32'(o_rsp_data), 32'(e[7:0]));
        end
      end
    end
  end

  // Host request driver; returns at posedge+1 after the handshake edge.
  task automatic host_req(input bit rd, input int bank, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [7:0] rdata);
    int w = 0;
    i_req_valid   = 1'b1;
    i_req_rd_n_wr = rd;
    i_req_addr    = {4'(bank), addr};
    i_req_wdata   = wd;
    @(negedge i_clk);
    while (!o_req_ready && w < 100) begin
      @(negedge i_clk);
      w++;
    end
    if (w >= 100) check("req_timeout", 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    eng_data[bank] = rdata;
    if (rd) exp_q.push_back({4'(bank), rdata});
`ifdef X_SRAM_SCHED_WR_ACK_EN
    else exp_q.push_back({4'(bank), 8'h00});
`endif
  endtask

  // Engine completion pulse for one bank.
  task automatic eng_done(input int bank);
    i_rdata[bank*8 +: 8] = eng_data[bank];
    i_ready[bank] = 1'b1;
    @(posedge i_clk); #1;
    i_ready = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
    check({tag, "_valid"},     32'(o_valid), 32'd0);
    check({tag, "_rd_n_wr"},   32'(o_rd_n_wr), 32'd0);
    check({tag, "_addr"},      32'(o_addr), 32'd0);
    check({tag, "_wdata"},     32'(o_wdata), 32'd0);
    check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    check({tag, "_rsp_bank"},  32'(o_rsp_bank), 32'd0);
    check({tag, "_rsp_data"},  32'(o_rsp_data), 32'd0);
    check({tag, "_fsm"},       32'(o_fsm_state), 32'd0);
  endtask

  initial begin
    for (int b = 0; b < NB; b++) eng_data[b] = 8'h00;
    // reset
    wait_cycles(3);
    check_reset_outputs("in_reset");
    i_rst = 1'b1;
    wait_cycles(1);
    check_reset_outputs("post_reset");

    // single read, engine accepts after 2 cycles
    acc_dly = 2;
    i_rsp_ready = 1'b1;
    vcnt3 = 0;
    host_req(1'b1, 3, 16'h0010, 8'h00, 8'hA5);
    check("t1_valid", 32'(o_valid), 32'h0008);
    check("t1_addr", 32'(o_addr), 32'h0010);
    check("t1_rd", 32'(o_rd_n_wr), 32'd1);
    check("t1_ready_dispatch", 32'(o_req_ready), 32'd0);
    wait_cycles(5);
    check("t1_valid_cycles", 32'(vcnt3), 32'd3);
    eng_done(3);
    check("t1_rsp_latency", 32'(o_rsp_valid), 32'd1);
    wait_cycles(2);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // out-of-order completion, in-order responses
    acc_dly = 0;
    host_req(1'b1, 5, 16'h0100, 8'h00, 8'h5A);
    host_req(1'b1, 2, 16'h0200, 8'h00, 8'h22);
    wait_cycles(3);
    eng_done(2);
    wait_cycles(3);
    check("t2_hold_order", 32'(o_rsp_valid), 32'd0);
    eng_done(5);
    check("t2_head_bank", 32'(o_rsp_bank), 32'd5);
    wait_cycles(3);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // same-bank stall until its response is popped
    i_rsp_ready = 1'b0;
    host_req(1'b1, 7, 16'h0700, 8'h00, 8'h77);
    wait_cycles(3);
    eng_done(7);
    i_req_valid = 1'b1;
    i_req_rd_n_wr = 1'b1;
    i_req_addr = {4'd7, 16'h0701};
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("t3_stall", 32'(o_req_ready), 32'd0);
    end
    @(posedge i_clk); #1;
    check("t3_rsp_pending", 32'(o_rsp_valid), 32'd1);
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    check("t3_pop_same_cycle", 32'(o_req_ready), 32'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("t3_ready_after_pop", 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    eng_data[7] = 8'h78;
    exp_q.push_back({4'd7, 8'h78});
    check("t3_valid", 32'(o_valid), 32'h0080);
    check("t3_addr", 32'(o_addr), 32'h0701);
    wait_cycles(3);
    eng_done(7);
    wait_cycles(3);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // all 16 banks, responses held back, completions in reverse order
    i_rsp_ready = 1'b0;
    for (int i = 0; i < NB; i++) perm[i] = i;
    for (int i = NB - 1; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < NB; i++)
      host_req(1'b1, perm[i], 16'($urandom_range(0, 65535)), 8'h00, 8'($urandom_range(0, 255)));
    wait_cycles(3);
    for (int i = NB - 1; i >= 0; i--) eng_done(perm[i]);
    i_req_addr = {4'(perm[0]), 16'h0000};
    @(negedge i_clk);
    check("t4_all_occupied", 32'(o_req_ready), 32'd0);
    check("t4_head_ready", 32'(o_rsp_valid), 32'd1);
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b1;
    wait_cycles(24);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // write to bank 1
    host_req(1'b0, 1, 16'h1234, 8'h3C, 8'hFF);
    check("t5_wdata", 32'(o_wdata), 32'h3C);
    check("t5_rd_n_wr", 32'(o_rd_n_wr), 32'd0);
    wait_cycles(3);
    eng_done(1);
`ifdef X_SRAM_SCHED_WR_ACK_EN
    check("t5_wr_rsp", 32'(o_rsp_valid), 32'd1);
`else
    check("t5_no_wr_rsp", 32'(o_rsp_valid), 32'd0);
    i_req_addr = {4'd1, 16'h0000};
    @(negedge i_clk);
    check("t5_bank_free", 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
`endif
    host_req(1'b1, 1, 16'h0042, 8'h00, 8'h11);
    wait_cycles(3);
    eng_done(1);
    wait_cycles(3);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // reset mid-dispatch with three banks busy
    i_rsp_ready = 1'b0;
    host_req(1'b1, 4, 16'h0004, 8'h00, 8'h44);
    host_req(1'b1, 8, 16'h0008, 8'h00, 8'h88);
    host_req(1'b1, 9, 16'h0009, 8'h00, 8'h99);
    wait_cycles(2);
    acc_dly = 50;
    host_req(1'b1, 10, 16'h000A, 8'h00, 8'hAA);
    check("t6_in_dispatch", 32'(o_fsm_state), 32'd1);
    i_rst = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    exp_q.delete();
    wait_cycles(2);
    i_rst = 1'b1;
    acc_dly = 0;
    i_rsp_ready = 1'b1;
    eng_done(4);
    wait_cycles(3);
    check("t6_stray_ready", 32'(o_rsp_valid), 32'd0);
    i_req_addr = {4'd4, 16'h0000};
    @(negedge i_clk);
    check("t6_bank4_free", 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/x_sram_sched.md
# x_sram_sched

Request scheduler between a single host port and the bank of `x_23K640_data` SPI SRAM engines.
- Decodes the bank from the upper address bits and drives that engine's valid/accept handshake over the shared rd_n_wr/addr/wdata bus.
- Allows one outstanding access per bank, so several banks run concurrently.
- Returns read data to the host strictly in request order.
- Sits between `x_driver` (or any host master) and the per-chip data engines; the engines are clocked off the common `x_23K640_sck` advance.

## Interface
Parameters:
- `p_banks`, default 16: number of engines. Legal values 2, 4, 8, 16. `BW = log2(p_banks)`.

Ports:
- `i_clk` in 1: system clock.
- `i_rst` in 1: reset, asynchronous, active-low.
- `i_req_valid` in 1: host request valid.
- `o_req_ready` out 1: request accepted when `i_req_valid & o_req_ready`.
- `i_req_rd_n_wr` in 1: 1 = read, 0 = write.
- `i_req_addr` in 16+BW: `[15+BW:16]` = bank, `[15:0]` = SRAM address.
- `i_req_wdata` in 8: write data.
- `o_rsp_valid` out 1: response valid.
- `i_rsp_ready` in 1: response popped when `o_rsp_valid & i_rsp_ready`.
- `o_rsp_bank` out BW: bank of the response.
- `o_rsp_data` out 8: read data; 0 for write acks.
- `o_valid` out p_banks: per-engine request valid.
- `i_accept` in p_banks: per-engine accept pulse.
- `o_rd_n_wr` out 1: shared engine command.
- `o_addr` out 16: shared engine address.
- `o_wdata` out 8: shared engine write data.
- `i_ready` in p_banks: per-engine completion pulse, one cycle.
- `i_rdata` in 8*p_banks: packed engine read data; bank b is at `[8b+7:8b]`.

## Operation
Per-bank state:
- `busy[b]`: dispatched and awaiting `i_ready[b]`.
- `done[b]`: completed, response pending.
- `trk[b]`: response tracked.
- `rdat[b]`: 8-bit captured read data.
- Bank b is occupied when `busy[b] | done[b]`.

Order FIFO:
- Depth p_banks, entries BW bits wide, read/write pointers wrap modulo p_banks, count is BW+1 bits.
- It cannot overflow, because it holds at most one entry per bank.

Dispatch FSM:
- **IDLE**
  - `o_req_ready = !occupied[req_bank] & !o_valid_any`.
  - On handshake: latch rd_n_wr/addr[15:0]/wdata into `o_rd_n_wr`/`o_addr`/`o_wdata`, set `o_valid[req_bank]`, record the tracked flag, go to DISPATCH.
- **DISPATCH**
  - `o_req_ready = 0`.
  - Hold `o_valid[bank]` and the shared bus stable until `i_accept[bank]`.
  - On accept: clear `o_valid`, set `busy[bank]`, and push bank to the FIFO if tracked. Return to IDLE.
- A request is tracked if it is a read, or if it is a write with `X_SRAM_SCHED_WR_ACK_EN` defined.

Completion:
- On `i_ready[b]` with `busy[b]`: clear `busy[b]`, capture `rdat[b] = i_rdata[b]` (reads) or 0 (writes), and set `done[b] = trk[b]`.
- `i_ready[b]` without `busy[b]` is ignored.
- `i_accept` on any bank other than the one currently dispatching is ignored.

Response:
- `o_rsp_valid = !fifo_empty & done[head]`, `o_rsp_bank = head`, `o_rsp_data = rdat[head]`.
- Response outputs are combinational from registers; `o_rsp_data` and `o_rsp_bank` are 0 when not valid.
- On pop: clear `done[head]`, advance the read pointer.
- A bank whose response is not at the head stays occupied, so requests to it stall (head-of-line ordering is intended).

Simultaneous events:
- Pop of bank x and request to bank x in the same cycle: the request is not accepted that cycle; it is accepted the next cycle.
- Push and pop in the same cycle: count is unchanged.

## Timing
Reset values:
- `o_req_ready` = 1.
- `o_valid` = 0, `o_rd_n_wr` = 0, `o_addr` = 0, `o_wdata` = 0.
- `o_rsp_valid` = 0, `o_rsp_bank` = 0, `o_rsp_data` = 0.
- FSM = IDLE; busy/done/FIFO cleared.

Latencies:
- Request handshake at cycle N → `o_valid[b]` high at N+1.
- Accept at cycle M → `o_valid` low and `o_req_ready` re-evaluated at M+1. Back-to-back dispatch rate is one per 2 cycles when the engine accepts immediately.
- `i_ready[b]` at cycle K with b at head → `o_rsp_valid` high at K+1.

Reset mid-operation: all state is discarded and engine valids are dropped. Late `i_ready`/`i_accept` pulses after reset are ignored because no bank is busy.

## Configuration
`X_SRAM_SCHED_WR_ACK_EN`:
- Defined: writes enter the order FIFO and produce a response with `o_rsp_data` = 0 after the engine completes.
- Undefined: writes are fire-and-forget. The bank frees on `i_ready`, no response is issued, and only reads occupy FIFO slots.

## Test plan
- Reset, then read bank 3 addr 0x0010. Engine 3 accepts after 2 cycles and returns 0xA5 → `o_valid[3]` high for 3 cycles; `o_addr` = 0x0010; response bank 3, data 0xA5.
- Reads to banks 5 then 2; engine 2 completes first → no response until bank 5 completes; then responses in order 5, 2.
- Second request to bank 7 while bank 7 is busy → `o_req_ready` = 0 until the bank 7 response is popped; the request dispatches 1 cycle later.
- Hold `i_rsp_ready` = 0 with 16 reads to all banks completed → `o_req_ready` stays 0; popping all 16 returns banks in issue order with correct data.
- Write 0x3C to bank 1 → with the macro, a response with bank 1, data 0x00; without it, no response and bank 1 is immediately reusable after `i_ready[1]`.
- Assert reset during DISPATCH with 3 banks busy → all outputs return to reset values; a stray `i_ready[4]` after reset produces no response.
